// File: rtl/fast_square_sweep_sequencer_if.sv
// Control/status bundle between the sweep sequencer and the RX top level.
// master = sequencer side, slave = daughterboard/datapath side.
interface fast_square_sweep_sequencer_if #(
    parameter int STEP_W = 5
);
    logic              enable;
    logic              sync_in;
    logic              lock_in;
    logic              clear_status;
    logic              freq_step_out;
    logic              rx_reset;
    logic              rx_next;
    logic              rx_record;
    logic [STEP_W-1:0] step_index;
    logic [15:0]       sweep_count;
    logic              busy;
    logic              lock_timeout;

    modport master (
        input  enable, sync_in, lock_in, clear_status,
        output freq_step_out, rx_reset, rx_next, rx_record,
               step_index, sweep_count, busy, lock_timeout
    );

    modport slave (
        output enable, sync_in, lock_in, clear_status,
        input  freq_step_out, rx_reset, rx_next, rx_record,
               step_index, sweep_count, busy, lock_timeout
    );
endinterface

// File: rtl/fast_square_sweep_sequencer.sv
// Stepped-frequency sweep sequencer for the fast-square RX datapath.
// Define SWEEP_LOCK_TIMEOUT_EN to bound the lock wait and enable the sticky lock_timeout flag.
module fast_square_sweep_sequencer #(
    parameter int NUM_FREQ_STEPS   = 32,
    parameter int STEP_W           = 5,
    parameter int SETTLE_TICKS     = 1000,
    parameter int RECORD_TICKS     = 35000,
    parameter int STEP_PULSE_TICKS = 4,
    parameter int TIMEOUT_TICKS    = 4096,
    parameter int CNT_W            = 16
) (
    input  logic clock,
    input  logic reset,
    fast_square_sweep_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, RST, WAIT_LOCK, SETTLE, RECORD, NEXT, STEP
    } state_t;

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0]  RECORD_LOAD = CNT_W'(RECORD_TICKS - 1);
    localparam logic [CNT_W-1:0]  PULSE_LOAD  = CNT_W'(STEP_PULSE_TICKS - 1);
    // The lock-wait load is harmless when the timeout is compiled out: WAIT_LOCK ignores the counter then.
    localparam logic [CNT_W-1:0]  WAIT_LOAD   = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NUM_FREQ_STEPS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [15:0]        sweep_q, sweep_d;
    logic               to_q, to_set;
    logic [1:0]         lock_sync_q;
    logic [2:0]         sync_sync_q;
    logic               lock_s, restart;
    logic               freq_q, rx_reset_q, rx_next_q, rx_record_q, busy_q;

    assign lock_s  = lock_sync_q[1];
    assign restart = sync_sync_q[1] & ~sync_sync_q[2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        sweep_d = sweep_q;
        to_set  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = '0;
        end else if (restart && state_q != IDLE) begin
            state_d = RST;
        end else begin
            case (state_q)
                IDLE: state_d = RST;
                RST: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = WAIT_LOAD;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
`ifdef SWEEP_LOCK_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        to_set  = 1'b1;
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
`endif
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = RECORD;
                        cnt_d   = RECORD_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RECORD: begin
                    if (cnt_q == '0) state_d = NEXT;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                NEXT: begin
                    if (step_q == LAST_STEP) begin
                        step_d  = '0;
                        sweep_d = sweep_q + 16'd1;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                    cnt_d   = PULSE_LOAD;
                    state_d = STEP;
                end
                STEP: begin
                    if (cnt_q == '0) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == RST) step_d = '0;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            step_q      <= '0;
            sweep_q     <= '0;
            to_q        <= 1'b0;
            lock_sync_q <= '0;
            sync_sync_q <= '0;
            freq_q      <= 1'b0;
            rx_reset_q  <= 1'b0;
            rx_next_q   <= 1'b0;
            rx_record_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], bus.lock_in};
            sync_sync_q <= {sync_sync_q[1:0], bus.sync_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            sweep_q     <= sweep_d;
            to_q        <= to_set | (to_q & ~bus.clear_status);
            freq_q      <= (state_d == NEXT) || (state_d == STEP);
            rx_reset_q  <= (state_d == RST);
            rx_next_q   <= (state_d == NEXT);
            rx_record_q <= (state_d == RECORD);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.freq_step_out = freq_q;
    assign bus.rx_reset      = rx_reset_q;
    assign bus.rx_next       = rx_next_q;
    assign bus.rx_record     = rx_record_q;
    assign bus.step_index    = step_q;
    assign bus.sweep_count   = sweep_q;
    assign bus.busy          = busy_q;
    assign bus.lock_timeout  = to_q;

endmodule

// File: tb/tb_fast_square_sweep_sequencer.sv
// Bench for fast_square_sweep_sequencer: schedule-based reference model plus directed scenarios.
module tb_fast_square_sweep_sequencer;
    localparam int NSTEP   = 4;
    localparam int STEP_W  = 2;
    localparam int SETTLE  = 3;
    localparam int RECORD  = 5;
    localparam int PULSE   = 2;
    localparam int TIMEOUT = 8;
`ifdef SWEEP_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fast_square_sweep_sequencer_if #(.STEP_W(STEP_W)) bus();

    fast_square_sweep_sequencer #(
        .NUM_FREQ_STEPS(NSTEP), .STEP_W(STEP_W), .SETTLE_TICKS(SETTLE),
        .RECORD_TICKS(RECORD), .STEP_PULSE_TICKS(PULSE),
        .TIMEOUT_TICKS(TIMEOUT), .CNT_W(16)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: per-step output schedule ----------------
    typedef struct packed {logic rs; logic nx; logic rc; logic fq;} vec_t;
    vec_t              plan[$];
    vec_t              cur;
    int                m_mode;   // 0 idle, 1 reset pulse, 2 waiting for lock, 3 playing a step schedule
    int                m_wait;
    logic [STEP_W-1:0] m_step;
    logic [15:0]       m_sweep;
    logic              m_to;
    logic [1:0]        m_lk;
    logic [2:0]        m_sy;

    task automatic model_reset();
        plan.delete();
        cur = '0; m_mode = 0; m_wait = 0; m_step = '0; m_sweep = '0; m_to = 1'b0;
        m_lk = '0; m_sy = '0;
    endtask

    task automatic start_step();
        plan.delete();
        repeat (SETTLE) plan.push_back(vec_t'(4'b0000));
        repeat (RECORD) plan.push_back(vec_t'(4'b0010));
        plan.push_back(vec_t'(4'b0101));
        repeat (PULSE) plan.push_back(vec_t'(4'b0001));
        cur = plan.pop_front();
        m_mode = 3;
    endtask

    task automatic model_step();
        logic lk, rs, setto;
        if (rst) begin
            model_reset();
            return;
        end
        lk = m_lk[1];
        rs = m_sy[1] & ~m_sy[2];
        m_lk = {m_lk[0], bus.lock_in};
        m_sy = {m_sy[1:0], bus.sync_in};
        setto = 1'b0;
        if (!bus.enable) begin
            m_mode = 0; m_step = '0; plan.delete(); cur = '0;
        end else if (m_mode == 0 || rs) begin
            m_mode = 1; m_step = '0; plan.delete(); cur = vec_t'(4'b1000);
        end else if (m_mode == 1) begin
            m_mode = 2; m_wait = 0; cur = '0;
        end else if (m_mode == 2) begin
            if (lk) start_step();
            else begin
                m_wait++;
                if (TO_EN && m_wait >= TIMEOUT) begin
                    setto = 1'b1;
                    start_step();
                end
            end
        end else begin
            if (cur.nx) begin
                if (m_step == STEP_W'(NSTEP - 1)) begin
                    m_step = '0;
                    m_sweep++;
                end else m_step++;
            end
            if (plan.size() == 0) begin
                m_mode = 2; m_wait = 0; cur = '0;
            end else cur = plan.pop_front();
        end
        if (setto) m_to = 1'b1;
        else if (bus.clear_status) m_to = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                check("outs_in_reset",
                      32'({bus.rx_reset, bus.rx_next, bus.rx_record, bus.freq_step_out,
                           bus.busy, bus.lock_timeout, bus.step_index, bus.sweep_count}), 32'd0);
            end else begin
                check("strobes", 32'({bus.rx_reset, bus.rx_next, bus.rx_record, bus.freq_step_out}),
                      32'(cur));
                check("status", 32'({bus.busy, bus.lock_timeout, bus.step_index, bus.sweep_count}),
                      32'({(m_mode != 0), m_to, m_step, m_sweep}));
            end
        end
    end

    // Lock stimulus: follows freq_step_out low with one cycle of delay, or is held.
    int   lock_mode = 0;
    logic lock_val  = 1'b1;
    logic prev_fq   = 1'b0;
    initial begin
        bus.lock_in = 1'b1;
        forever begin
            @(negedge clk);
            if (lock_mode == 0) bus.lock_in = ~prev_fq;
            else                bus.lock_in = lock_val;
            prev_fq = bus.freq_step_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, %0d of %0d comparisons failing", n_fail, n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        bit          ok;
        int          rc, nc, fc, run_rc, run_fc, max_rc, max_fc, cnt, nx;
        logic [1:0]  last;
        logic [15:0] s0;
        int          seq[$];

        bus.enable = 1'b0; bus.sync_in = 1'b0; bus.clear_status = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_state",
                 32'({bus.rx_reset, bus.rx_next, bus.rx_record, bus.freq_step_out,
                      bus.busy, bus.lock_timeout, bus.step_index, bus.sweep_count}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // enable rising: rx_reset in the next cycle only
        bus.enable = 1'b1;
        @(negedge clk); #1;
        check("rx_reset_first", 32'(bus.rx_reset), 32'd1);
        check("busy_first", 32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        check("rx_reset_second", 32'(bus.rx_reset), 32'd0);

        // full sweep
        rc = 0; nc = 0; fc = 0; run_rc = 0; run_fc = 0; max_rc = 0; max_fc = 0; ok = 1'b0;
        last = bus.step_index;
        seq.push_back(int'(last));
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #1;
            if (bus.rx_record) begin rc++; run_rc++; end else run_rc = 0;
            if (bus.freq_step_out) begin fc++; run_fc++; end else run_fc = 0;
            if (bus.rx_next) nc++;
            if (run_rc > max_rc) max_rc = run_rc;
            if (run_fc > max_fc) max_fc = run_fc;
            if (bus.step_index != last) begin
                last = bus.step_index;
                seq.push_back(int'(last));
            end
            if (bus.sweep_count == 16'd1 && !bus.freq_step_out) ok = 1'b1;
        end
        check("sweep_done", 32'(ok), 32'd1);
        check("record_cycles", 32'(rc), 32'd20);
        check("next_cycles", 32'(nc), 32'd4);
        check("freq_cycles", 32'(fc), 32'd12);
        check("record_run", 32'(max_rc), 32'd5);
        check("freq_run", 32'(max_fc), 32'd3);
        check("step_seq_len", 32'(seq.size()), 32'd5);
        for (int i = 0; i < seq.size(); i++) check("step_seq", 32'(seq[i]), 32'(i % NSTEP));
        check("sweep_one", 32'(bus.sweep_count), 32'd1);

        // restart during record cycle 3 of step 2
        cnt = 0; ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (bus.rx_record && bus.step_index == 2'd2) begin
                cnt++;
                if (cnt == 3) ok = 1'b1;
            end
        end
        check("restart_reach", 32'(ok), 32'd1);
        s0 = bus.sweep_count;
        bus.sync_in = 1'b1;
        ok = 1'b0; nx = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk); #1;
            if (bus.rx_next) nx++;
            if (bus.rx_reset) ok = 1'b1;
        end
        check("restart_rx_reset", 32'(ok), 32'd1);
        check("restart_record_low", 32'(bus.rx_record), 32'd0);
        check("restart_step", 32'(bus.step_index), 32'd0);
        check("restart_sweep", 32'(bus.sweep_count), 32'(s0));
        check("restart_no_next", 32'(nx), 32'd0);
        bus.sync_in = 1'b0;

        // enable low in SETTLE, restart edge arriving on the same edge
        bus.enable = 1'b0; lock_mode = 1; lock_val = 1'b1;
        repeat (5) @(negedge clk);
        bus.enable = 1'b1;                     // cycle c
        @(negedge clk); #1;                    // c+1
        check("el_rx_reset", 32'(bus.rx_reset), 32'd1);
        repeat (2) @(negedge clk);             // c+3
        bus.sync_in = 1'b1;
        repeat (2) @(negedge clk); #1;         // c+5
        check("el_settle_busy", 32'(bus.busy), 32'd1);
        check("el_settle_norec", 32'(bus.rx_record), 32'd0);
        bus.enable = 1'b0;
        @(negedge clk); #1;                    // c+6
        check("el_idle_busy", 32'(bus.busy), 32'd0);
        check("el_no_rx_reset", 32'(bus.rx_reset), 32'd0);
        check("el_step", 32'(bus.step_index), 32'd0);
        @(negedge clk); #1;
        check("el_still_idle", 32'({bus.busy, bus.rx_reset}), 32'd0);
        bus.sync_in = 1'b0;

        // async reset mid-RECORD
        lock_mode = 0;
        repeat (4) @(negedge clk);
        bus.enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk); #1;
            if (bus.rx_record) ok = 1'b1;
        end
        check("ar_reach_record", 32'(ok), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 check("ar_outputs_zero",
                 32'({bus.rx_reset, bus.rx_next, bus.rx_record, bus.freq_step_out,
                      bus.busy, bus.lock_timeout, bus.step_index, bus.sweep_count}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("ar_rx_reset_after", 32'(bus.rx_reset), 32'd1);

        // sweep_count wrap at 65535
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (bus.rx_record && bus.step_index == 2'd0) ok = 1'b1;
        end
        check("wrap_reach", 32'(ok), 32'd1);
        force dut.sweep_q = 16'hFFFF;
        m_sweep = 16'hFFFF;
        @(negedge clk);
        release dut.sweep_q;
        #1 check("wrap_preset", 32'(bus.sweep_count), 32'h0000FFFF);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            if (bus.sweep_count != 16'hFFFF) ok = 1'b1;
        end
        check("wrap_seen", 32'(ok), 32'd1);
        check("wrap_value", 32'(bus.sweep_count), 32'd0);
        check("wrap_step", 32'(bus.step_index), 32'd0);

        // lock held low
        bus.enable = 1'b0; lock_mode = 1; lock_val = 1'b0;
        repeat (5) @(negedge clk);
        bus.enable = 1'b1;                     // cycle c
`ifdef SWEEP_LOCK_TIMEOUT_EN
        repeat (9) @(negedge clk); #1;         // c+9: last WAIT_LOCK cycle
        check("to_not_yet", 32'(bus.lock_timeout), 32'd0);
        @(negedge clk); #1;                    // c+10
        check("to_set", 32'(bus.lock_timeout), 32'd1);
        check("to_settle_norec", 32'(bus.rx_record), 32'd0);
        repeat (3) @(negedge clk); #1;         // c+13
        check("to_record", 32'(bus.rx_record), 32'd1);
        bus.clear_status = 1'b1;
        @(negedge clk); #1;
        bus.clear_status = 1'b0;
        check("to_cleared", 32'(bus.lock_timeout), 32'd0);
        repeat (5) @(negedge clk);
`else
        rc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.rx_record) rc++;
        end
        check("nolock_no_record", 32'(rc), 32'd0);
        check("nolock_to_zero", 32'(bus.lock_timeout), 32'd0);
        check("nolock_busy", 32'(bus.busy), 32'd1);
        bus.clear_status = 1'b1;
        @(negedge clk);
        bus.clear_status = 1'b0;
`endif
        bus.enable = 1'b0;
        repeat (3) @(negedge clk); #1;
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fast_square_sweep_sequencer.md
# fast_square_sweep_sequencer

Sequences the fast-square receive datapath through a stepped-frequency sweep.
- Steps the daughterboard synthesizer with a freq-step pulse and waits for its lock indication.
- Applies a settle interval, then gates one record window per step.
- Drives the baseband capture strobes (rx_reset, rx_next, rx_record) and keeps step/sweep bookkeeping.
- Sits in the RX top level between the io_tx_b daughterboard pins and the fast_square_bb instances.

## Interface
Parameters:
- NUM_FREQ_STEPS, 32, steps per sweep (≥2)
- STEP_W, 5, width of step_index (≥ clog2(NUM_FREQ_STEPS))
- SETTLE_TICKS, 1000, clock64 cycles between lock and record (≥1)
- RECORD_TICKS, 35000, record window length in cycles (≥1)
- STEP_PULSE_TICKS, 4, freq_step_out high time (≥1)
- TIMEOUT_TICKS, 4096, lock wait limit (used only with timeout compiled in)
- CNT_W, 16, width of the shared down-counter (must hold every tick parameter minus 1)

Ports:
- clock  in  1  clock64
- reset  in  1  asynchronous, active-high
- enable  in  1  run sweep; low forces IDLE
- sync_in  in  1  asynchronous restart request from daughterboard, level
- lock_in  in  1  asynchronous synthesizer lock, level
- clear_status  in  1  clears lock_timeout
- freq_step_out  out  1  synthesizer step pulse
- rx_reset  out  1  one-cycle datapath reset
- rx_next  out  1  one-cycle datapath step strobe
- rx_record  out  1  record gate
- step_index  out  STEP_W  current step, 0..NUM_FREQ_STEPS-1
- sweep_count  out  16  completed sweeps, wraps at 65535→0
- busy  out  1  state ≠ IDLE
- lock_timeout  out  1  sticky lock-wait timeout flag

## Operation
- sync_in and lock_in pass through two-flop synchronizers; sync_in is then edge-detected, rising edge = restart.
- Moore FSM states: IDLE, RST, WAIT_LOCK, SETTLE, RECORD, NEXT, STEP.
- IDLE: enable=1 → RST.
- RST: rx_reset=1; clear step_index → WAIT_LOCK.
- WAIT_LOCK: synced lock=1 → SETTLE, counter loads SETTLE_TICKS-1.
- SETTLE: counter at 0 → RECORD, counter loads RECORD_TICKS-1.
- RECORD: rx_record=1; counter at 0 → NEXT.
- NEXT: rx_next=1 and freq_step_out=1.
  - step_index==NUM_FREQ_STEPS-1: step_index wraps to 0 and sweep_count increments.
  - Otherwise step_index increments.
  - Counter loads STEP_PULSE_TICKS-1 → STEP.
- STEP: freq_step_out=1; counter at 0 → WAIT_LOCK.
- Priority, highest first:
  - enable=0: → IDLE, step_index cleared; sweep_count held.
  - Restart edge while not IDLE: → RST (aborts any record window).
  - Normal transition.
- lock_timeout: clear_status clears it; a same-cycle set wins over the clear.
- Reset values: state IDLE, counter 0, every output 0, step_index 0, sweep_count 0, lock_timeout 0.

## Timing
- All outputs are registered or decoded from registered state; no combinational input-to-output path.
- enable rising, sampled at edge N: rx_reset high in cycle N+1 only.
- lock_in has 2 cycles of synchronizer latency before WAIT_LOCK sees it.
- From the first WAIT_LOCK cycle that sees synced lock:
  - SETTLE_TICKS cycles of SETTLE, then rx_record high for exactly RECORD_TICKS consecutive cycles.
  - rx_next high for exactly 1 cycle.
  - freq_step_out high for exactly STEP_PULSE_TICKS+1 cycles (NEXT plus STEP).
- The synthesizer drops lock during the step pulse. WAIT_LOCK evaluates lock from the cycle after STEP, so stale lock is not masked; the board must guarantee the drop.
- Restart edge during RECORD: rx_record low the next cycle, rx_reset high that same cycle.

## Configuration
- SWEEP_LOCK_TIMEOUT_EN defined:
  - WAIT_LOCK counts cycles.
  - After TIMEOUT_TICKS cycles without lock: lock_timeout sets, FSM proceeds to SETTLE as if locked.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - lock_timeout is tied 0; TIMEOUT_TICKS is unused.

## Test plan
Bench parameters: NUM_FREQ_STEPS=4, SETTLE_TICKS=3, RECORD_TICKS=5, STEP_PULSE_TICKS=2, TIMEOUT_TICKS=8.
- Full sweep: enable=1, lock follows freq_step_out low with 1-cycle delay.
  - Per step: rx_record 5 cycles, rx_next 1 cycle, freq_step_out 3 cycles.
  - step_index 0→1→2→3→0; sweep_count 0→1 on the 3→0 wrap.
- Restart: sync_in rising during record cycle 3 of step 2 → rx_record drops, rx_reset pulse, step_index=0, sweep_count unchanged.
- enable low mid-SETTLE, with a sync_in edge in the same cycle → IDLE next cycle, busy=0, no rx_reset, step_index=0.
- Async reset asserted mid-RECORD → every output 0 immediately; after release with enable=1, rx_reset pulse occurs.
- Lock held low with SWEEP_LOCK_TIMEOUT_EN → lock_timeout=1 after 8 WAIT_LOCK cycles, rx_record follows 3 cycles later; clear_status clears it. Without the macro: no rx_record ever, lock_timeout=0.
- Run 65536 sweeps (force sweep_count near 65535) → wraps to 0.
